// File: rtl/i2s_rx.sv
// I2S / left-justified serial audio receiver: synchronizes the async bus, assembles
// left/right words and presents complete stereo pairs with frame-error and lock tracking.
module i2s_rx #(
    parameter int WIDTH   = 16,
    parameter int DELAY   = 0,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             pll_lock,
    input  logic             i2s_bck,
    input  logic             i2s_ws,
    input  logic             i2s_din,
    output logic [WIDTH-1:0] audio_l,
    output logic [WIDTH-1:0] audio_r,
    output logic             sample_valid,
    output logic             frame_err,
    output logic             locked
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_e;

    logic [2:0]       bck_sync_q;
    logic [1:0]       ws_sync_q, din_sync_q;
    state_e           state_q, state_d;
    logic             ws_prev_q, ws_prev_d, prev_ok_q, prev_ok_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
    logic [WIDTH-2:0] word_q, word_d;
    logic [WIDTH-1:0] word_n, hold_q, hold_d;
    logic             left_ok_q, left_ok_d, seen_q, seen_d, locked_q, locked_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [WIDTH-1:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic             valid_q, valid_d, ferr_q, ferr_d;
    logic             bck_rise, ws_s, din_s, ws_chg, shift_en;

    assign bck_rise = bck_sync_q[1] & ~bck_sync_q[2];
    assign ws_s     = ws_sync_q[1];
    assign din_s    = din_sync_q[1];
    assign ws_chg   = prev_ok_q & (ws_s ^ ws_prev_q);
    assign word_n   = {word_q, din_s};

    // Two-flop synchronizers; the third bck flop feeds the rising-edge detector.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            bck_sync_q <= 3'b000;
            ws_sync_q  <= 2'b00;
            din_sync_q <= 2'b00;
        end else begin
            bck_sync_q <= {bck_sync_q[1:0], i2s_bck};
            ws_sync_q  <= {ws_sync_q[0], i2s_ws};
            din_sync_q <= {din_sync_q[0], i2s_din};
        end
    end

    // Word framing, pair assembly, lock and timeout next-state logic.
    always_comb begin
        state_d   = state_q;
        ws_prev_d = ws_prev_q;
        prev_ok_d = prev_ok_q;
        cnt_d     = cnt_q;
        cnt_base  = cnt_q;
        word_d    = word_q;
        hold_d    = hold_q;
        left_ok_d = left_ok_q;
        seen_d    = seen_q;
        locked_d  = locked_q;
        tmo_d     = tmo_q;
        audio_l_d = audio_l_q;
        audio_r_d = audio_r_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        shift_en  = 1'b0;
        if (bck_rise) begin
            tmo_d     = '0;
            ws_prev_d = ws_s;
            prev_ok_d = 1'b1;
            if (ws_chg) begin
                state_d  = RUN;
                cnt_base = '0;
                shift_en = (DELAY == 0);
                if ((state_q == RUN) && (cnt_q != CNT_FULL)) begin
                    ferr_d    = 1'b1;
                    left_ok_d = 1'b0;
                    seen_d    = 1'b0;
                    locked_d  = 1'b0;
                end else begin
                    ferr_d = 1'b0;
                end
            end else begin
                shift_en = (state_q == RUN);
            end
            cnt_d = cnt_base;
            if (shift_en && (cnt_base != CNT_FULL)) begin
                word_d = word_n[WIDTH-2:0];
                cnt_d  = cnt_base + CW'(1);
                // A word completes on its last counted bit, not on the following ws change.
                if (cnt_base == CNT_LAST) begin
                    if (!ws_s) begin
                        hold_d    = word_n;
                        left_ok_d = 1'b1;
                    end else if (left_ok_d) begin
                        audio_l_d = hold_q;
                        audio_r_d = word_n;
                        valid_d   = 1'b1;
                        left_ok_d = 1'b0;
                        if (seen_d) begin
                            locked_d = 1'b1;
                        end else begin
                            seen_d = 1'b1;
                        end
                    end else begin
                        left_ok_d = 1'b0;
                    end
                end else begin
                    hold_d = hold_q;
                end
            end else begin
                word_d = word_q;
            end
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_q == TMO_LAST) begin
                state_d   = HUNT;
                prev_ok_d = 1'b0;
                left_ok_d = 1'b0;
                seen_d    = 1'b0;
                locked_d  = 1'b0;
            end else begin
                state_d = state_q;
            end
        end else begin
            tmo_d = TMO_MAX;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            state_q   <= HUNT;
            ws_prev_q <= 1'b0;
            prev_ok_q <= 1'b0;
            cnt_q     <= '0;
            word_q    <= '0;
            hold_q    <= '0;
            left_ok_q <= 1'b0;
            seen_q    <= 1'b0;
            locked_q  <= 1'b0;
            tmo_q     <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ws_prev_q <= ws_prev_d;
            prev_ok_q <= prev_ok_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            hold_q    <= hold_d;
            left_ok_q <= left_ok_d;
            seen_q    <= seen_d;
            locked_q  <= locked_d;
            tmo_q     <= tmo_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign audio_l      = audio_l_q;
    assign audio_r      = audio_r_q;
    assign sample_valid = valid_q;
    assign frame_err    = ferr_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: word-level stream model against a left-justified and a Philips receiver
// sharing one serial bus.
module tb_i2s_rx;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic pll_lock, bck, ws, din;
    logic [W-1:0] l0, r0, l1, r1;
    logic sv0, fe0, lk0, sv1, fe1, lk1;

    i2s_rx #(.WIDTH(W), .DELAY(0), .TIMEOUT(255)) dut0 (
        .clk(clk), .pll_lock(pll_lock), .i2s_bck(bck), .i2s_ws(ws), .i2s_din(din),
        .audio_l(l0), .audio_r(r0), .sample_valid(sv0), .frame_err(fe0), .locked(lk0));
    i2s_rx #(.WIDTH(W), .DELAY(1), .TIMEOUT(255)) dut1 (
        .clk(clk), .pll_lock(pll_lock), .i2s_bck(bck), .i2s_ws(ws), .i2s_din(din),
        .audio_l(l1), .audio_r(r1), .sample_valid(sv1), .frame_err(fe1), .locked(lk1));

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed events from both receivers
    logic [W-1:0] gl0[$], gr0[$], gl1[$], gr1[$];
    int fe_cnt0 = 0, fe_cnt1 = 0, both0 = 0, both1 = 0;
    always @(negedge clk) begin
        if (sv0) begin gl0.push_back(l0); gr0.push_back(r0); end
        if (sv1) begin gl1.push_back(l1); gr1.push_back(r1); end
        if (fe0) fe_cnt0++;
        if (fe1) fe_cnt1++;
        if (sv0 && fe0) both0++;
        if (sv1 && fe1) both1++;
    end

    // Word-level reference model
    int s_ch[$], s_n[$];
    int unsigned s_val[$];
    logic [W-1:0] e_l[$], e_r[$];
    int e_err;
    logic [W-1:0] m_l, m_r, m_hold;
    bit m_left_ok, m_seen, m_locked;
    int base0, base1, fbase0, fbase1, bbase0, bbase1;

    task automatic add_word(input int ch, input int unsigned val, input int n);
        s_ch.push_back(ch); s_val.push_back(val); s_n.push_back(n);
    endtask

    task automatic m_hunt();
        m_left_ok = 1'b0; m_seen = 1'b0; m_locked = 1'b0;
    endtask

    task automatic run_stream(input int d, input int half);
        int eff;
        int unsigned top;
        int sws[$];
        int sbit[$];
        e_l.delete(); e_r.delete(); e_err = 0;
        base0 = gl0.size(); base1 = gl1.size();
        fbase0 = fe_cnt0; fbase1 = fe_cnt1; bbase0 = both0; bbase1 = both1;
        for (int k = 0; k < s_ch.size(); k++) begin
            // Philips: the LSB rides on the next word's ws-change slot and is never counted.
            eff = s_n[k] - d;
            if (k > 0) begin
                if (eff >= W) begin
                    top = s_val[k] >> (s_n[k] - W);
                    if (s_ch[k] == 0) begin
                        m_hold = top[W-1:0]; m_left_ok = 1'b1;
                    end else if (m_left_ok) begin
                        e_l.push_back(m_hold); e_r.push_back(top[W-1:0]);
                        m_l = m_hold; m_r = top[W-1:0]; m_left_ok = 1'b0;
                        if (m_seen) m_locked = 1'b1; else m_seen = 1'b1;
                    end
                end else if (k < s_ch.size() - 1) begin
                    e_err++; m_left_ok = 1'b0; m_seen = 1'b0; m_locked = 1'b0;
                end
            end
            for (int i = s_n[k] - 1; i >= 0; i--) begin
                sws.push_back(s_ch[k]);
                sbit.push_back(int'((s_val[k] >> i) & 32'd1));
            end
        end
        for (int j = 0; j < sws.size(); j++) begin
            ws  = (sws[j] != 0);
            din = (d != 0) ? ((j == 0) ? 1'b0 : (sbit[j-1] != 0)) : (sbit[j] != 0);
            repeat (half) @(posedge clk);
            bck = 1'b1;
            repeat (half) @(posedge clk);
            bck = 1'b0;
        end
        repeat (20) @(posedge clk);
        s_ch.delete(); s_val.delete(); s_n.delete();
    endtask

    task automatic check_stream(input int sel, input string nm);
        logic [W-1:0] ql[$], qr[$];
        int nfe, nbo;
        logic [W-1:0] al, ar;
        logic lk;
        @(negedge clk);
        if (sel == 0) begin
            for (int i = base0; i < gl0.size(); i++) begin ql.push_back(gl0[i]); qr.push_back(gr0[i]); end
            nfe = fe_cnt0 - fbase0; nbo = both0 - bbase0; al = l0; ar = r0; lk = lk0;
        end else begin
            for (int i = base1; i < gl1.size(); i++) begin ql.push_back(gl1[i]); qr.push_back(gr1[i]); end
            nfe = fe_cnt1 - fbase1; nbo = both1 - bbase1; al = l1; ar = r1; lk = lk1;
        end
        check_eq({nm, "_npairs"}, ql.size(), e_l.size());
        for (int i = 0; i < ql.size() && i < e_l.size(); i++) begin
            check_eq({nm, "_pair_l"}, ql[i], e_l[i]);
            check_eq({nm, "_pair_r"}, qr[i], e_r[i]);
        end
        check_eq({nm, "_frame_err"}, nfe, e_err);
        check_eq({nm, "_valid_and_err"}, nbo, 0);
        check_eq({nm, "_audio_l"}, al, m_l);
        check_eq({nm, "_audio_r"}, ar, m_r);
        check_eq({nm, "_locked"}, lk, m_locked);
    endtask

    task automatic check_zero(input string nm);
        check_eq({nm, "_audio_l"}, l0, 0);
        check_eq({nm, "_audio_r"}, r0, 0);
        check_eq({nm, "_valid"}, sv0, 0);
        check_eq({nm, "_ferr"}, fe0, 0);
        check_eq({nm, "_locked"}, lk0, 0);
    endtask

    function automatic int unsigned rnd16();
        return $urandom & 32'hFFFF;
    endfunction

    initial begin
        pll_lock = 1'b0; bck = 1'b0; ws = 1'b0; din = 1'b0;
        m_l = '0; m_r = '0; m_hold = '0; m_hunt();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        pll_lock = 1'b1;
        repeat (5) @(posedge clk);

        // Directed left-justified pairs
        add_word(1, 32'h5, 3);
        add_word(0, 32'h8001, 16); add_word(1, 32'h7FFE, 16);
        add_word(0, 32'h1234, 16); add_word(1, 32'hABCD, 16);
        run_stream(0, 20);
        check_stream(0, "s1");
        check_eq("s1_last_l", l0, 32'h1234);
        check_eq("s1_last_r", r0, 32'hABCD);
        repeat (300) @(posedge clk); m_hunt();

        // Random frames with a truncated left word in the middle
        add_word(1, 32'h1F, 5);
        for (int f = 0; f < 3; f++) begin add_word(0, rnd16(), 16); add_word(1, rnd16(), 16); end
        begin
            int sn;
            sn = $urandom_range(4, 15);
            add_word(0, $urandom & ((32'd1 << sn) - 32'd1), sn);
        end
        add_word(1, rnd16(), 16);
        for (int f = 0; f < 2; f++) begin add_word(0, rnd16(), 16); add_word(1, rnd16(), 16); end
        run_stream(0, 20);
        check_stream(0, "s2");
        repeat (300) @(posedge clk); m_hunt();

        // bck stops mid right word, then restarts mid right word
        add_word(1, 32'h3, 4);
        for (int f = 0; f < 2; f++) begin add_word(0, rnd16(), 16); add_word(1, rnd16(), 16); end
        add_word(0, rnd16(), 16); add_word(1, $urandom & 32'h7F, 7);
        run_stream(0, 20);
        check_stream(0, "s3");
        repeat (100) @(negedge clk);
        check_eq("s3_lock_mid_gap", lk0, 1'b1);
        repeat (200) @(negedge clk);
        check_eq("s3_lock_timeout", lk0, 1'b0);
        check_eq("s3_ferr_timeout", fe_cnt0 - fbase0, 0);
        check_eq("s3_hold_l", l0, m_l);
        check_eq("s3_hold_r", r0, m_r);
        m_hunt();
        add_word(1, $urandom & 32'h1FF, 9);
        add_word(0, rnd16(), 16); add_word(1, rnd16(), 16);
        run_stream(0, 20);
        check_stream(0, "s3b");
        repeat (300) @(posedge clk); m_hunt();

        // Philips format with 18-bit slots on the DELAY=1 receiver
        add_word(1, 32'h2A, 6);
        add_word(0, (32'hFFFF << 2) | ($urandom & 32'h3), 18);
        add_word(1, $urandom & 32'h3, 18);
        run_stream(1, 20);
        check_stream(1, "s4");
        check_eq("s4_l", l1, 32'hFFFF);
        check_eq("s4_r", r1, 32'h0000);
        repeat (300) @(posedge clk); m_hunt();

        // pll_lock pulse mid right word
        add_word(1, 32'h6, 3);
        add_word(0, rnd16(), 16); add_word(1, rnd16(), 16);
        add_word(0, rnd16(), 16); add_word(1, $urandom & 32'hFF, 8);
        run_stream(0, 20);
        check_stream(0, "s5");
        @(negedge clk);
        pll_lock = 1'b0;
        #1;
        check_zero("s5_pulse");
        @(negedge clk);
        pll_lock = 1'b1;
        m_l = '0; m_r = '0; m_hunt();
        add_word(1, $urandom & 32'hFF, 8);
        for (int f = 0; f < 2; f++) begin add_word(0, rnd16(), 16); add_word(1, rnd16(), 16); end
        run_stream(0, 20);
        check_stream(0, "s5b");
        repeat (300) @(posedge clk); m_hunt();

        // Transmitter loopback at bck = clk/42
        add_word(1, 32'h1, 5);
        for (int f = 0; f < 4; f++) begin add_word(0, 32'h0800, 16); add_word(1, 32'h0800, 16); end
        run_stream(0, 21);
        check_stream(0, "s6");
        check_eq("s6_l", l0, 32'h0800);
        check_eq("s6_r", r0, 32'h0800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter WIDTH, default 16: bits per channel word.
REQ-002 Parameter DELAY, default 0: 0 = MSB on the same bck edge as the ws change (left-justified, the format our own transmitter emits); 1 = MSB one bck after the ws change (Philips I2S).
REQ-003 Parameter TIMEOUT, default 255: clk cycles with no bck rising edge before loss of lock is declared.
REQ-004 clk  in  1  system clock; all logic on posedge clk.
REQ-005 pll_lock  in  1  reset, asynchronous, active-low.
REQ-006 i2s_bck  in  1  serial bit clock, asynchronous to clk.
REQ-007 i2s_ws  in  1  word select, asynchronous to clk; 0 = left, 1 = right.
REQ-008 i2s_din  in  1  serial data, MSB first, asynchronous to clk.
REQ-009 audio_l  out  WIDTH  last complete left sample, two's complement.
REQ-010 audio_r  out  WIDTH  last complete right sample, two's complement.
REQ-011 sample_valid  out  1  one-clk pulse when audio_l/audio_r update.
REQ-012 frame_err  out  1  one-clk pulse on a short word.
REQ-013 locked  out  1  level; high while frames are being received cleanly.

Function
REQ-014 i2s_bck, i2s_ws and i2s_din SHALL each pass through a two-flop synchronizer; a third bck flop SHALL provide rising-edge detection.
REQ-015 ws and din SHALL be sampled only on the clk cycle in which a synchronized bck rising edge is detected.
REQ-016 Correct operation is required only when bck high and low phases are each at least 3 clk periods.
REQ-017 States: HUNT (waiting for the first ws change), RUN. Reset and timeout enter HUNT. The first sampled ws change in HUNT enters RUN without an error, and that word starts as in RUN.
REQ-018 In RUN, a sampled ws value different from the previous sample starts a new word: clear the bit counter, then shift in din at this edge (DELAY=0) or from the next edge (DELAY=1).
REQ-019 Each counted bit SHALL shift into the word register MSB-first; bits beyond WIDTH in a word are ignored; the counter saturates at WIDTH.
REQ-020 When a left word reaches WIDTH bits, it SHALL be copied to a left holding register and marked left_ok.
REQ-021 When a right word reaches WIDTH bits and left_ok=1, on that same clk edge audio_l <= holding, audio_r <= word, sample_valid = 1, left_ok cleared.
REQ-022 A right word completed with left_ok=0 SHALL be discarded silently.
REQ-023 Short word: in RUN, a ws change while the ending word has fewer than WIDTH bits SHALL pulse frame_err for one clk, clear left_ok and clear locked; the new word still starts normally.
REQ-024 locked SHALL rise on the second consecutive sample_valid with no intervening frame_err or timeout, and stays high until the next frame_err, timeout or reset.
REQ-025 The timeout counter SHALL clear on every detected bck rising edge and saturate at TIMEOUT; reaching TIMEOUT SHALL clear locked and left_ok and enter HUNT, with no frame_err.
REQ-026 audio_l/audio_r SHALL hold their value between updates, including across errors and timeouts.
REQ-027 sample_valid and frame_err are mutually exclusive. A ws change completing the right word, as in REQ-018, is evaluated for REQ-023 only; output update uses the completion at the last counted bit.

Reset
REQ-028 While pll_lock=0: audio_l=0, audio_r=0, sample_valid=0, frame_err=0, locked=0, state HUNT, counters and synchronizers 0, left_ok=0.
REQ-029 Deassertion mid-frame SHALL discard the partial frame, with no output until a ws change followed by a full left and right word.

Verification
REQ-030 DELAY=0, bck = 40 clk period; send L=0x8001, R=0x7FFE, then L=0x1234, R=0xABCD -> sample_valid pulses twice, last audio_l=0x1234, audio_r=0xABCD; locked=1 after the second pulse.
REQ-031 Locked stream, then the left word truncated to 12 bits -> frame_err one clk, locked=0; that frame gives no sample_valid; the next two good frames re-assert locked.
REQ-032 Stop bck for 300 clk while locked -> locked=0 at 255 clk after the last edge, no frame_err; restarting mid-right-word gives no output until a full L/R pair arrives.
REQ-033 DELAY=1, Philips-format L=0xFFFF, R=0x0000 with 18-bit words (extra bits ignored) -> audio_l=0xFFFF, audio_r=0x0000, no frame_err.
REQ-034 pll_lock pulsed low for 1 clk mid right word -> all outputs 0 immediately; the first sample_valid comes only after a later complete L/R pair.
REQ-035 Loopback from our I2S transmitter (bck = clk/42, audio_mix=0x4000, AUDIO_SHIFT=3) -> steady audio_l=audio_r=0x0800, locked=1, no frame_err.
